// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor:
//   - state_t    : FSM state encoding (S_IDLE=0, S_SHIFT=1, S_DONE=2)
//   - WIDTH_MIN/WIDTH_MAX and width_ok() : legal operand width range check
//   - cnt_width(): bit counter width, $clog2(width) with a 1-bit minimum
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned w);
        if (w > 2) begin
            return unsigned'($clog2(w));
        end
        return 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor_full_subtractor
// Combinational one-bit full subtractor cell computing A - B - Bin.
// Ports:
//   A    in  minuend bit
//   B    in  subtrahend bit
//   Bin  in  borrow in
//   D    out difference bit
//   Bout out borrow out
// -----------------------------------------------------------------------------
module serial_subtractor_full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    logic w_axb;

    assign w_axb = A ^ B;
    assign D     = w_axb ^ Bin;
    // Borrow when B exceeds A outright, or when they tie and a borrow is pending
    assign Bout  = (~A & B) | (~w_axb & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial WIDTH-bit subtractor, DIFF = A - B - Bin, one bit per clock, LSB
// first, through a single full-subtractor cell and a borrow flip-flop, behind a
// start/busy/done handshake.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   start  in  launch request, accepted in IDLE or DONE
//   A, B   in  operands, captured on an accepted start
//   Bin    in  borrow in, captured on an accepted start
//   busy   out high during the WIDTH shift cycles
//   done   out one-cycle pulse when the result is valid
//   DIFF   out result, held until the next result is delivered
//   Bout   out final borrow (A < B + Bin, unsigned)
//   Ovf    out signed overflow
//   Zero   out DIFF == 0
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int unsigned CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range 2..32");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CntW-1:0]  r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_next;

    serial_subtractor_full_subtractor u_full_subtractor (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_br),
        .D    (w_d),
        .Bout (w_bo)
    );

    // Result fills from the MSB side so after WIDTH shifts bit 0 sits at the LSB
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SHIFT;
                        r_a     <= A;
                        r_b     <= B;
                        r_res   <= '0;
                        r_br    <= Bin;
                        r_cnt   <= '0;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_bo;
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == LastCnt) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_res_next;
                        r_bout  <= w_bo;
                        // w_d is the result MSB on the final shift
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_zero  <= (w_res_next == '0);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign DIFF = r_diff;
    assign Bout = r_bout;
    assign Ovf  = r_ovf;
    assign Zero = r_zero;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes DIFF = A - B - Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- It is the arithmetic counterpart of the existing ripple full-adder blocks, and the sequential, area-minimal alternative to a parallel subtractor.
- Sits behind a start/busy/done handshake so a controller can launch an operation and collect the result.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on a rising clk edge while the block is ready (IDLE or DONE)
A  input  WIDTH  minuend; captured on an accepted start
B  input  WIDTH  subtrahend; captured on an accepted start
Bin  input  1  borrow-in; captured on an accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result is valid
DIFF  output  WIDTH  result A - B - Bin mod 2^WIDTH; held until the next accepted start
Bout  output  1  final borrow out; 1 when A < B + Bin (unsigned)
Ovf  output  1  signed overflow, defined as (A[msb] != B[msb]) && (DIFF[msb] != A[msb])
Zero  output  1  DIFF == 0

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. busy, done, DIFF, Bout, Ovf and Zero are all 0. Operand shift registers, borrow flip-flop and bit counter are cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE to SHIFT: start=1 at edge t.
  - A and B load into shift registers.
  - Borrow flip-flop loads Bin.
  - Counter loads 0.
  - A_msb and B_msb are latched for Ovf.
- SHIFT, each edge:
  - The cell computes d = a0 ^ b0 ^ br and bo = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the result register from the MSB side; the operand registers shift right.
  - br <= bo; counter increments.
- SHIFT to DONE: at the edge where the counter reaches WIDTH-1, i.e. after exactly WIDTH SHIFT cycles. busy is high for all WIDTH SHIFT cycles.
- Outputs in DONE: done=1 for exactly one cycle, first asserted at cycle t+WIDTH+1. In that same cycle:
  - DIFF shows the full result register.
  - Bout shows the final borrow.
  - Ovf and Zero are valid.
  - All four hold until the next accepted start.
- DONE next state:
  - start=1: go to SHIFT with new operands (back-to-back operation, no IDLE bubble).
  - Otherwise: go to IDLE.
- Start while busy: ignored with no side effects; the operands on A/B/Bin are not sampled.
- Input changes: A/B/Bin changing after acceptance has no effect on the result.
- Reset mid-operation: immediate return to reset values, and the partial result is discarded. The first start after rst_n rises is accepted normally.
- Edge cases: B=0 with Bin=0 gives DIFF=A, Bout=0. A=B with Bin=1 gives DIFF=all ones, Bout=1.
- Counter width: $clog2(WIDTH), minimum 1 bit.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams: S_IDLE=0, S_SHIFT=1, S_DONE=2)
  - a WIDTH range-check constant
- Sub-module full_subtractor: combinational, ports A, B, Bin, D, Bout. It is instantiated once and is also unit-testable standalone across all 8 input combinations.

Test Plan:
- WIDTH=8, A=0x5A, B=0x23, Bin=0, start 1 cycle -> busy for 8 cycles; done pulses at t+9 with DIFF=0x37, Bout=0, Ovf=0, Zero=0.
- A=0x00, B=0x01, Bin=0 -> DIFF=0xFF, Bout=1, Ovf=0, Zero=0.
- A=0x10, B=0x0F, Bin=1 -> DIFF=0x00, Bout=0, Zero=1.
- A=0x80, B=0x01, Bin=0 -> DIFF=0x7F, Ovf=1, Bout=0.
  - Then start held high in the DONE cycle with A=0x05, B=0x07 -> next done exactly 9 cycles later, DIFF=0xFE, Bout=1.
- Start pulse at SHIFT cycle 3 with different operands -> ignored; the original result is delivered on schedule.
  - Then rst_n low at SHIFT cycle 4 -> all outputs 0 immediately, state IDLE.
  - A fresh start then produces the correct result.
